// File: rtl/demux_pkg.sv
// Shared constants for the registered 1-to-16 word demultiplexer.
package demux_pkg;
  localparam int WIDTH = 32;
  localparam int LANES = 16;
  localparam int SEL_W = 4;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_SEQ  = 1'b1;
endpackage

// File: rtl/demux_lane.sv
// One output lane: a word holding register plus a sticky valid flag.
module demux_lane #(
  parameter int WIDTH = demux_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             ack,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  // NOTE: sequential state uses non-blocking assignments so every lane and
  // the pointer sample the same pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (wr_en) begin
      // A write wins over a same-cycle ack: the old word counts as consumed.
      data  <= wr_data;
      valid <= 1'b1;
    end else if (ack) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1t16_32.sv
// Registered 1-to-16 demultiplexer: steers a valid/ready word stream into
// sixteen lane registers, by explicit select or by a wrapping pointer.
module demux_1t16_32 #(
  parameter int WIDTH = demux_pkg::WIDTH,
  parameter int LANES = demux_pkg::LANES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mode,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  input  logic [demux_pkg::SEL_W-1:0] in_sel,
  output logic [LANES*WIDTH-1:0]      out_data,
  output logic [LANES-1:0]            out_valid,
  input  logic [LANES-1:0]            out_ack,
  output logic [demux_pkg::SEL_W-1:0] ptr,
  output logic                        frame_done
);
  import demux_pkg::*;

  logic [SEL_W-1:0] target;
  logic             accept;
  logic             seq;

  assign seq      = (mode == MODE_SEQ);
  assign target   = seq ? ptr : in_sel;
  // Ready looks only at the target lane, never at in_valid.
  assign in_ready = rst_n & (~out_valid[target] | out_ack[target]);
  assign accept   = in_valid & in_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    demux_lane #(.WIDTH(WIDTH)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (accept && (target == SEL_W'(i))),
      .wr_data (in_data),
      .ack     (out_ack[i]),
      .data    (out_data[i*WIDTH +: WIDTH]),
      .valid   (out_valid[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && seq && (ptr == '1);
      if (accept && seq) begin
        ptr <= ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_demux_1t16_32.sv
// Self-checking bench: directed scenarios plus random traffic against a lane model.
module tb_demux_1t16_32;

  logic          clk;
  logic          rst_n;
  logic          mode;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic [3:0]    in_sel;
  logic [511:0]  out_data;
  logic [15:0]   out_valid;
  logic [15:0]   out_ack;
  logic [3:0]    ptr;
  logic          frame_done;

  int tests = 0;
  int fails = 0;

  // Behavioural reference: array of lane words, a valid bitmap, a pointer.
  logic [31:0] m_data [16];
  logic [15:0] m_valid;
  int          m_ptr;
  logic        m_fd;

  demux_1t16_32 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ack    (out_ack),
    .ptr        (ptr),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int target_lane();
    return mode ? m_ptr : int'(in_sel);
  endfunction

  task automatic model_edge(input bit acc);
    int t;
    t = target_lane();
    if (!rst_n) begin
      foreach (m_data[i]) m_data[i] = '0;
      m_valid = '0;
      m_ptr   = 0;
      m_fd    = 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (acc && i == t) begin
          m_data[i]  = in_data;
          m_valid[i] = 1'b1;
        end else if (out_ack[i]) begin
          m_valid[i] = 1'b0;
        end
      end
      m_fd = acc && mode && (m_ptr == 15);
      if (acc && mode) m_ptr = (m_ptr + 1) % 16;
    end
  endtask

  task automatic check_state();
    check("out_valid", {16'h0, out_valid}, {16'h0, m_valid});
    check("ptr", {28'h0, ptr}, m_ptr);
    check("frame_done", {31'h0, frame_done}, {31'h0, m_fd});
    for (int i = 0; i < 16; i++) begin
      check($sformatf("lane%0d", i), out_data[i*32 +: 32], m_data[i]);
    end
  endtask

  // Apply the current inputs for one clock: check ready, clock, check state.
  task automatic step();
    bit exp_ready;
    int t;
    #1;
    t = target_lane();
    exp_ready = rst_n && (!m_valid[t] || out_ack[t]);
    check("in_ready", {31'h0, in_ready}, {31'h0, exp_ready});
    @(posedge clk);
    model_edge(exp_ready && in_valid);
    #1;
    check_state();
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    out_ack  = '0;
    in_data  = '0;
    in_sel   = '0;
  endtask

  initial begin
    m_valid = '0;
    m_ptr   = 0;
    m_fd    = 1'b0;
    foreach (m_data[i]) m_data[i] = '0;

    // Reset held two cycles with in_valid high: never ready.
    rst_n    = 1'b0;
    mode     = 1'b0;
    idle_inputs();
    in_valid = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    idle_inputs();
    step();
    check("post_reset_valid", {16'h0, out_valid}, 32'h0);

    // Addressed fill: lane k <= k.
    mode = 1'b0;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_sel   = 4'(k);
      in_data  = 32'(k);
      step();
    end
    idle_inputs();
    check("fill_all_valid", {16'h0, out_valid}, 32'h0000_FFFF);
    check("mux_sel_13", out_data[13*32 +: 32], 32'd13);

    // Backpressure on full lane 5, then same-cycle ack and replace.
    in_valid = 1'b1;
    in_sel   = 4'd5;
    in_data  = 32'hA5;
    #1;
    check("bp_ready_low", {31'h0, in_ready}, 32'h0);
    step();
    check("bp_lane5_held", out_data[5*32 +: 32], 32'd5);
    out_ack = 16'h0020;
    step();
    check("ack_replace_valid5", {31'h0, out_valid[5]}, 32'h1);
    check("ack_replace_data5", out_data[5*32 +: 32], 32'hA5);

    // Drain everything, then a stray ack on empty lanes changes nothing.
    idle_inputs();
    out_ack = 16'hFFFF;
    step();
    step();
    check("stray_ack_ptr", {28'h0, ptr}, 32'h0);
    check("stray_ack_lane7", out_data[7*32 +: 32], 32'd7);

    // Sequential wrap with every lane acked each cycle.
    mode = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_data  = 32'(100 + k);
      out_ack  = 16'hFFFF;
      step();
      if (k < 15) check("seq_no_frame", {31'h0, frame_done}, 32'h0);
    end
    check("seq_frame_done", {31'h0, frame_done}, 32'h1);
    check("seq_ptr_wrap", {28'h0, ptr}, 32'h0);
    check("seq_lane15", out_data[15*32 +: 32], 32'd115);
    idle_inputs();
    step();
    check("frame_done_pulse", {31'h0, frame_done}, 32'h0);

    // Random traffic, occasional reset.
    for (int n = 0; n < 400; n++) begin
      rst_n    = ($urandom_range(0, 49) != 0);
      mode     = 1'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      in_sel   = 4'($urandom);
      in_data  = $urandom;
      out_ack  = 16'($urandom & $urandom & $urandom);
      step();
    end
    rst_n = 1'b1;
    idle_inputs();
    out_ack = 16'hFFFF;
    step();

    // Reset after seven sequential accepts.
    mode = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      in_data  = 32'(200 + k);
      out_ack  = '0;
      step();
    end
    check("mid_ptr_7", {28'h0, ptr}, (m_ptr % 16));
    rst_n = 1'b0;
    step();
    check("mid_reset_ptr", {28'h0, ptr}, 32'h0);
    check("mid_reset_valid", {16'h0, out_valid}, 32'h0);
    check("mid_reset_fd", {31'h0, frame_done}, 32'h0);
    rst_n = 1'b1;
    idle_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
